// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit (and future receive) blocks.
//   tx_state_t  : frame sequencer states
//   TX_IDLE_LVL : line level while no frame is in flight (mark)
//   cnt_w()     : counter width for a modulus n (ceil(log2(n)), at least 1)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LVL = 1'b1;

  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CLK_DIV-1 and wraps; tick marks the last cycle
// of each bit period so the owner can advance on that edge. clr holds the
// count at zero so a new frame always starts on a fresh period.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : hold the counter at 0
//   tick       : high in the final cycle of a bit period
//   cnt        : current position within the bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = cnt_w(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
  assign cnt  = cnt_q;

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: accepts DATA_W-bit words on a valid/ready handshake
// and sends each as start bit, LSB-first data, optional parity, stop bit(s).
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even, or odd when PARITY_ODD=1).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data, in_valid   : byte source
//   in_ready            : high only while idle
//   tx                  : serial line, idles high
//   busy                : frame in progress
//   frame_done          : pulse in the last cycle of the final stop bit
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line at mark, in_ready high, waiting for a byte
// START  | start bit (low) for one bit period
// DATA   | DATA_W data bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS stop bits (high)
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_W);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              frame_done_q, frame_done_d;
  logic              par_q, par_d;
  logic              baud_tick;
  logic [CNT_W-1:0]  baud_cnt;
  logic              accept;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (baud_tick),
    .cnt  (baud_cnt)
  );

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = in_data;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
`endif
        end
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        // bit counter is reused to count stop bits
        if (baud_tick) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // registered outputs follow the state being entered
    case (state_d)
      START:   tx_d = ~TX_IDLE_LVL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = TX_IDLE_LVL;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);

    // raise the pulse one cycle early so it lands in the final stop cycle
    frame_done_d = (state_q == STOP) && (bit_q == BIT_W'(STOP_BITS - 1)) &&
                   (baud_cnt == CNT_W'(CLK_DIV - 2));
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      par_q        <= 1'b0;
      tx_q         <= TX_IDLE_LVL;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      par_q        <= par_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
module tb_uart_byte_tx;

  localparam int CLK_DIV = 4;
  localparam int DW      = 8;
  localparam int SB      = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DW + P + SB;
  localparam int LEN   = NBITS * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, busy, frame_done;
  logic          in_ready_o, tx_o, busy_o, frame_done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_byte_tx #(
    .CLK_DIV(CLK_DIV), .DATA_W(DW), .STOP_BITS(SB), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  // same stimulus, odd parity: differs from dut only in the parity bit
  uart_byte_tx #(
    .CLK_DIV(CLK_DIV), .DATA_W(DW), .STOP_BITS(SB), .PARITY_ODD(1)
  ) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_o), .tx(tx_o), .busy(busy_o), .frame_done(frame_done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // expected line level per bit period, built directly from the byte
  function automatic logic [NBITS-1:0] build_frame(input logic [7:0] b, input bit odd);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = b[i];
    if (P == 1) f[1+DW] = ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ odd;
    return f;
  endfunction

  // reset value that was applied at the most recent edge
  logic rst_seen = 1'b0;
  bit   mon_en   = 1'b0;
  always @(posedge clk) begin
    rst_seen <= rst_n;
    mon_en   <= 1'b1;
  end

  bit               in_frame = 1'b0;
  int               cyc = 0;
  int               idle_cnt = 0;
  int               last_gap = -1;
  int               frames = 0;
  int               dones = 0;
  logic [NBITS-1:0] fbits, fbits_odd;
  logic [7:0]       cur;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_seen) begin
        if (in_frame) begin
          in_frame = 1'b0;
          check("abort_tx", 32'(tx), 32'd1);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_done", 32'(frame_done), 32'd0);
        end else begin
          check("rst_state", 32'({tx, busy, in_ready, frame_done}), 32'b1000);
        end
        idle_cnt = 0;
      end else begin
        if (!in_frame && tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got start bit with no byte pending (t=%0t)", $time);
          end else begin
            cur       = exp_q.pop_front();
            fbits     = build_frame(cur, 1'b0);
            fbits_odd = build_frame(cur, 1'b1);
            in_frame  = 1'b1;
            cyc       = 0;
            last_gap  = idle_cnt;
          end
        end
        if (in_frame) begin
          check("tx", 32'(tx), 32'(fbits[cyc/CLK_DIV]));
          check("tx_odd", 32'(tx_o), 32'(fbits_odd[cyc/CLK_DIV]));
          check("busy", 32'(busy), 32'd1);
          check("in_ready", 32'(in_ready), 32'd0);
          check("frame_done", 32'(frame_done), 32'(cyc == LEN - 1));
          check("odd_ctrl", 32'({in_ready_o, busy_o, frame_done_o}),
                32'({1'b0, 1'b1, (cyc == LEN - 1)}));
          if (frame_done) dones++;
          if (cyc == LEN - 1) begin
            in_frame = 1'b0;
            frames++;
            idle_cnt = 0;
          end else begin
            cyc++;
          end
        end else begin
          check("idle", 32'({tx, busy, in_ready, frame_done, tx_o, busy_o, in_ready_o, frame_done_o}),
                32'b1010_1010);
          idle_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit drop_valid);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > LEN * 4) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready never rose for byte %0h", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    if (drop_valid) in_valid = 1'b0;
  endtask

  // byte changes every cycle while the transmitter is busy
  task automatic send_changing();
    logic [7:0] v;
    bit         ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    for (int i = 0; i < LEN * 4; i++) begin
      @(negedge clk);
      if (in_ready) begin
        v = in_data;
        @(posedge clk);
        exp_q.push_back(v);
        #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      in_data = 8'($urandom);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL changing_timeout: no accept within budget");
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < LEN * 4; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !in_frame) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: frame did not complete");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    send(8'h55, 1'b1);
    wait_idle();

    send(8'hA3, 1'b0);
    send(8'h0F, 1'b1);
    wait_idle();
    check("b2b_gap", 32'(last_gap), 32'd1);

    send(8'h07, 1'b1);
    wait_idle();

    // reset during data bit 3 (cycles 16..19 after accept)
    send(8'hFF, 1'b1);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_dones", 32'(dones), 32'd4);
    send(8'h81, 1'b1);
    wait_idle();

    send(8'h3C, 1'b0);
    send_changing();
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle();

    check("frames", 32'(frames), 32'd13);
    check("dones", 32'(dones), 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
